// File: rtl/metronome_pkg.sv
// Shared types and parameter defaults for the bar-counting metronome.
package metronome_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned MIN_PERIOD_DEF   = 2;
  localparam int unsigned GATE_CYC_DEF     = 1000;
  localparam int unsigned ACC_GATE_CYC_DEF = 2000;

endpackage

// File: rtl/metronome_bar_if.sv
// Control inputs and tick/gate outputs of metronome_bar, named from the core's side.
interface metronome_bar_if #(
  parameter int unsigned CNT_W  = 34,
  parameter int unsigned BEAT_W = 4,
  parameter int unsigned SUB_W  = 3
);
  logic              i_enable;
  logic              i_sync;
  logic [CNT_W-1:0]  i_period;
  logic              i_period_load;
  logic [BEAT_W-1:0] i_beats;
  logic [SUB_W-1:0]  i_subdiv;
  logic              o_tick;
  logic              o_beat;
  logic              o_accent;
  logic [BEAT_W-1:0] o_beat_idx;
  logic [SUB_W-1:0]  o_sub_idx;
  logic              o_gate;
  logic              o_running;

  modport slave (
    input  i_enable, i_sync, i_period, i_period_load, i_beats, i_subdiv,
    output o_tick, o_beat, o_accent, o_beat_idx, o_sub_idx, o_gate, o_running
  );

  modport master (
    output i_enable, i_sync, i_period, i_period_load, i_beats, i_subdiv,
    input  o_tick, o_beat, o_accent, o_beat_idx, o_sub_idx, o_gate, o_running
  );
endinterface

// File: rtl/metronome_gate_stretch.sv
// Retriggerable gate: high for LEN (or ACC_LEN on accent) cycles from the trigger edge.
// Gate rises on the same edge that registers the trigger; no backpressure.
module metronome_gate_stretch #(
  parameter int unsigned LEN     = 1000,
  parameter int unsigned ACC_LEN = 2000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_trig,
  input  logic i_acc,
  output logic o_gate
);

  localparam int unsigned MAXL = (ACC_LEN > LEN) ? ACC_LEN : LEN;
  localparam int unsigned CW   = $clog2(MAXL + 1);

  logic [CW-1:0] r_left;
  logic          r_gate;

  // r_left counts the cycles still owed after the current one
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_left <= '0;
      r_gate <= 1'b0;
    end else if (i_clr) begin
      r_left <= '0;
      r_gate <= 1'b0;
    end else if (i_trig) begin
      r_gate <= 1'b1;
      r_left <= i_acc ? CW'(ACC_LEN - 1) : CW'(LEN - 1);
    end else if (r_left != '0) begin
      r_left <= r_left - CW'(1);
    end else begin
      r_gate <= 1'b0;
    end
  end

  assign o_gate = r_gate;

endmodule

// File: rtl/metronome_bar.sv
// Subdivision tick generator with beat/bar indexing, accent and stretched gate.
// First tick one cycle after enable/sync, then every period_q cycles; no backpressure.
module metronome_bar
  import metronome_pkg::*;
#(
  parameter int unsigned CNT_W        = 34,
  parameter int unsigned BEAT_W       = 4,
  parameter int unsigned SUB_W        = 3,
  parameter int unsigned GATE_CYC     = GATE_CYC_DEF,
  parameter int unsigned ACC_GATE_CYC = ACC_GATE_CYC_DEF,
  parameter int unsigned MIN_PERIOD   = MIN_PERIOD_DEF
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  metronome_bar_if.slave io_bus
);

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]  r_period, w_period_nxt;
  logic [CNT_W-1:0]  r_pend, w_pend_nxt;
  logic              r_pend_vld, w_pend_vld_nxt;
  logic [BEAT_W-1:0] r_beats, w_beats_nxt;
  logic [SUB_W-1:0]  r_subdiv, w_subdiv_nxt;
  logic [BEAT_W-1:0] r_beat_idx, w_beat_idx_nxt;
  logic [SUB_W-1:0]  r_sub_idx, w_sub_idx_nxt;
  logic              r_tick, w_tick_nxt;
  logic              r_beat, w_beat_nxt;
  logic              r_accent, w_accent_nxt;
  logic              w_apply;
  logic              w_gate;

  logic [CNT_W-1:0]  w_load_val;
  logic [BEAT_W-1:0] w_beats_in;
  logic [SUB_W-1:0]  w_subdiv_in;
  logic              w_boundary;

  assign w_load_val  = (io_bus.i_period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : io_bus.i_period;
  assign w_beats_in  = (io_bus.i_beats == '0) ? BEAT_W'(1) : io_bus.i_beats;
  assign w_subdiv_in = (io_bus.i_subdiv == '0) ? SUB_W'(1) : io_bus.i_subdiv;
  // period_q only moves on a boundary, so this compare never skips past it
  assign w_boundary  = (r_cnt == r_period - CNT_W'(1));

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_period_nxt   = r_period;
    w_pend_nxt     = r_pend;
    w_pend_vld_nxt = r_pend_vld;
    w_beats_nxt    = r_beats;
    w_subdiv_nxt   = r_subdiv;
    w_beat_idx_nxt = r_beat_idx;
    w_sub_idx_nxt  = r_sub_idx;
    w_tick_nxt     = 1'b0;
    w_beat_nxt     = 1'b0;
    w_accent_nxt   = 1'b0;
    w_apply        = 1'b0;

    if (io_bus.i_period_load) begin
      if (r_state == IDLE) begin
        w_period_nxt   = w_load_val;
        w_pend_vld_nxt = 1'b0;
      end else begin
        w_pend_nxt     = w_load_val;
        w_pend_vld_nxt = 1'b1;
      end
    end

    if (!io_bus.i_enable) begin
      w_state_nxt    = IDLE;
      w_cnt_nxt      = '0;
      w_beat_idx_nxt = '0;
      w_sub_idx_nxt  = '0;
    end else if (r_state == IDLE || io_bus.i_sync) begin
      w_state_nxt    = RUN;
      w_cnt_nxt      = '0;
      w_beat_idx_nxt = '0;
      w_sub_idx_nxt  = '0;
      w_beats_nxt    = w_beats_in;
      w_subdiv_nxt   = w_subdiv_in;
      w_tick_nxt     = 1'b1;
      w_beat_nxt     = 1'b1;
      w_accent_nxt   = 1'b1;
      w_apply        = 1'b1;
    end else if (w_boundary) begin
      w_cnt_nxt  = '0;
      w_tick_nxt = 1'b1;
      w_apply    = 1'b1;
      if (r_sub_idx == r_subdiv - SUB_W'(1)) begin
        w_sub_idx_nxt = '0;
        if (r_beat_idx == r_beats - BEAT_W'(1)) begin
          w_beat_idx_nxt = '0;
          w_beats_nxt    = w_beats_in;
          w_subdiv_nxt   = w_subdiv_in;
        end else begin
          w_beat_idx_nxt = r_beat_idx + BEAT_W'(1);
        end
      end else begin
        w_sub_idx_nxt = r_sub_idx + SUB_W'(1);
      end
      w_beat_nxt   = (w_sub_idx_nxt == '0);
      w_accent_nxt = w_beat_nxt && (w_beat_idx_nxt == '0);
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    // a load on the boundary edge beats anything already pending
    if (w_apply) begin
      if (io_bus.i_period_load) begin
        w_period_nxt   = w_load_val;
        w_pend_vld_nxt = 1'b0;
      end else if (r_pend_vld) begin
        w_period_nxt   = r_pend;
        w_pend_vld_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_period   <= CNT_W'(MIN_PERIOD);
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_beats    <= BEAT_W'(1);
      r_subdiv   <= SUB_W'(1);
      r_beat_idx <= '0;
      r_sub_idx  <= '0;
      r_tick     <= 1'b0;
      r_beat     <= 1'b0;
      r_accent   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_period   <= w_period_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_beats    <= w_beats_nxt;
      r_subdiv   <= w_subdiv_nxt;
      r_beat_idx <= w_beat_idx_nxt;
      r_sub_idx  <= w_sub_idx_nxt;
      r_tick     <= w_tick_nxt;
      r_beat     <= w_beat_nxt;
      r_accent   <= w_accent_nxt;
    end
  end

  metronome_gate_stretch #(
    .LEN    (GATE_CYC),
    .ACC_LEN(ACC_GATE_CYC)
  ) u_gate (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_clr    (~io_bus.i_enable),
    .i_trig   (w_beat_nxt),
    .i_acc    (w_accent_nxt),
    .o_gate   (w_gate)
  );

  assign io_bus.o_tick     = r_tick;
  assign io_bus.o_beat     = r_beat;
  assign io_bus.o_accent   = r_accent;
  assign io_bus.o_beat_idx = r_beat_idx;
  assign io_bus.o_sub_idx  = r_sub_idx;
  assign io_bus.o_gate     = w_gate;
  assign io_bus.o_running  = (r_state == RUN);

endmodule

// File: tb/tb_metronome_bar.sv
// Scoreboard bench: stimulus queues expected ticks and output levels, a negedge monitor checks them.
module tb_metronome_bar;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic done  = 1'b0;

  typedef struct {
    int         cyc;
    logic       beat;
    logic       acc;
    logic [3:0] bi;
    logic [2:0] si;
  } tick_t;

  typedef struct {
    int          cyc;
    string       name;
    logic [11:0] mask;
    logic [11:0] val;
  } lvl_t;

  tick_t tick_q[$];
  lvl_t  lvl_q[$];

  localparam logic [11:0] M_ALL  = 12'hFFF;
  localparam logic [11:0] M_GATE = 12'h100;
  localparam logic [11:0] M_STOP = 12'h9FF;

  metronome_bar_if #(.CNT_W(34), .BEAT_W(4), .SUB_W(3)) bus ();

  metronome_bar #(
    .CNT_W(34), .BEAT_W(4), .SUB_W(3),
    .GATE_CYC(3), .ACC_GATE_CYC(6), .MIN_PERIOD(2)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .io_bus   (bus)
  );

  // {tick, beat, accent, gate, running, beat_idx[3:0], sub_idx[2:0]}
  logic [11:0] snap;
  assign snap = {bus.o_tick, bus.o_beat, bus.o_accent, bus.o_gate, bus.o_running,
                 bus.o_beat_idx, bus.o_sub_idx};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: no completion by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin : monitor
    tick_t t;
    lvl_t  l;
    while (tick_q.size() > 0 && tick_q[0].cyc < cyc) begin
      t = tick_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missed_tick: no tick at cycle %0d where one was required", t.cyc);
    end
    if (bus.o_tick === 1'b1) begin
      n_cmp++;
      if (tick_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_tick: tick at cycle %0d, none required", cyc);
      end else begin
        t = tick_q.pop_front();
        if (t.cyc != cyc ||
            {bus.o_beat, bus.o_accent, bus.o_beat_idx, bus.o_sub_idx} !== {t.beat, t.acc, t.bi, t.si}) begin
          n_bad++;
          $display("FAIL tick: got cyc=%0d beat=%0b acc=%0b bi=%0d si=%0d, required cyc=%0d beat=%0b acc=%0b bi=%0d si=%0d",
                   cyc, bus.o_beat, bus.o_accent, bus.o_beat_idx, bus.o_sub_idx,
                   t.cyc, t.beat, t.acc, t.bi, t.si);
        end
      end
    end
    while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
      l = lvl_q.pop_front();
      n_cmp++;
      if (l.cyc != cyc || (snap & l.mask) !== (l.val & l.mask)) begin
        n_bad++;
        $display("FAIL %s: cycle %0d got %03h required %03h (mask %03h, due cycle %0d)",
                 l.name, cyc, snap & l.mask, l.val & l.mask, l.mask, l.cyc);
      end
    end
    if (done) begin
      n_cmp++;
      if (tick_q.size() != 0 || lvl_q.size() != 0) begin
        n_bad++;
        $display("FAIL drain: %0d ticks and %0d level checks left, required 0", tick_q.size(), lvl_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_tick(input int c, input logic beat, input logic acc,
                           input logic [3:0] bi, input logic [2:0] si);
    tick_t t;
    t.cyc = c; t.beat = beat; t.acc = acc; t.bi = bi; t.si = si;
    tick_q.push_back(t);
  endtask

  task automatic push_lvl(input int c, input string name, input logic [11:0] mask, input logic [11:0] val);
    lvl_t l;
    l.cyc = c; l.name = name; l.mask = mask; l.val = val;
    lvl_q.push_back(l);
  endtask

  task automatic pulse_load(input int c, input logic [33:0] val);
    at_cyc(c);
    bus.i_period      = val;
    bus.i_period_load = 1'b1;
    at_cyc(c + 1);
    bus.i_period_load = 1'b0;
  endtask

  task automatic pulse_sync(input int c);
    at_cyc(c);
    bus.i_sync = 1'b1;
    at_cyc(c + 1);
    bus.i_sync = 1'b0;
  endtask

  int b, b2, b3, b4;

  initial begin
    bus.i_enable      = 1'b0;
    bus.i_sync        = 1'b0;
    bus.i_period      = '0;
    bus.i_period_load = 1'b0;
    bus.i_beats       = 4'd4;
    bus.i_subdiv      = 3'd2;

    push_lvl(2, "reset_state", M_ALL, 12'h000);
    at_cyc(3);
    rst_n = 1'b1;

    // basic count, glitch-free period change, resync, clamp of a running load
    pulse_load(4, 34'd5);
    b = 6;
    push_tick(b + 1,   1, 1, 0, 0);
    push_tick(b + 6,   0, 0, 0, 1);
    push_tick(b + 11,  1, 0, 1, 0);
    push_tick(b + 16,  0, 0, 1, 1);
    push_tick(b + 21,  1, 0, 2, 0);
    push_tick(b + 26,  0, 0, 2, 1);
    push_tick(b + 31,  1, 0, 3, 0);
    push_tick(b + 36,  0, 0, 3, 1);
    push_tick(b + 41,  1, 1, 0, 0);
    push_tick(b + 46,  0, 0, 0, 1);
    push_tick(b + 55,  1, 0, 1, 0);
    push_tick(b + 64,  0, 0, 1, 1);
    push_tick(b + 73,  1, 0, 2, 0);
    push_tick(b + 76,  1, 1, 0, 0);
    push_tick(b + 85,  0, 0, 0, 1);
    push_tick(b + 94,  1, 0, 1, 0);
    push_tick(b + 103, 0, 0, 1, 1);
    push_tick(b + 105, 1, 0, 2, 0);
    push_tick(b + 107, 0, 0, 2, 1);
    push_lvl(b + 109, "stop_phase1", M_STOP, 12'h000);
    at_cyc(b);
    bus.i_enable = 1'b1;
    pulse_load(b + 43, 34'd9);
    pulse_sync(b + 75);
    pulse_load(b + 96, 34'd1);
    at_cyc(b + 108);
    bus.i_enable = 1'b0;

    // bar-boundary reconfiguration, beats=0, period 0 clamp, continuous gate
    b2 = b + 112;
    at_cyc(b2 - 3);
    bus.i_beats  = 4'd4;
    bus.i_subdiv = 3'd1;
    pulse_load(b2 - 3, 34'd0);
    push_tick(b2 + 1,  1, 1, 0, 0);
    push_tick(b2 + 3,  1, 0, 1, 0);
    push_tick(b2 + 5,  1, 0, 2, 0);
    push_tick(b2 + 7,  1, 0, 3, 0);
    push_tick(b2 + 9,  1, 1, 0, 0);
    push_tick(b2 + 11, 1, 0, 1, 0);
    push_tick(b2 + 13, 1, 0, 2, 0);
    push_tick(b2 + 15, 1, 1, 0, 0);
    push_tick(b2 + 17, 1, 1, 0, 0);
    push_tick(b2 + 19, 1, 1, 0, 0);
    for (int c = 1; c <= 20; c++) push_lvl(b2 + c, "gate_continuous", M_GATE, 12'h100);
    at_cyc(b2);
    bus.i_enable = 1'b1;
    at_cyc(b2 + 4);
    bus.i_beats = 4'd3;
    at_cyc(b2 + 12);
    bus.i_beats = 4'd0;
    at_cyc(b2 + 20);
    bus.i_enable = 1'b0;

    // gate lengths, stop mid-gate, re-enable, async reset
    b3 = b2 + 24;
    at_cyc(b3 - 3);
    bus.i_beats  = 4'd2;
    bus.i_subdiv = 3'd1;
    pulse_load(b3 - 3, 34'd10);
    push_tick(b3 + 1,  1, 1, 0, 0);
    push_tick(b3 + 11, 1, 0, 1, 0);
    push_tick(b3 + 16, 1, 1, 0, 0);
    push_tick(b3 + 26, 1, 0, 1, 0);
    for (int c = 1; c <= 12; c++)
      push_lvl(b3 + c, "gate_len", M_GATE, (c <= 6 || c >= 11) ? 12'h100 : 12'h000);
    push_lvl(b3 + 13, "stop_mid_gate", M_STOP, 12'h000);
    push_lvl(b3 + 26, "pre_reset", 12'h1F8, 12'h188);
    push_lvl(b3 + 27, "async_reset", M_ALL, 12'h000);
    at_cyc(b3);
    bus.i_enable = 1'b1;
    at_cyc(b3 + 12);
    bus.i_enable = 1'b0;
    at_cyc(b3 + 15);
    bus.i_enable = 1'b1;
    at_cyc(b3 + 27);
    #3;
    rst_n        = 1'b0;
    bus.i_enable = 1'b0;
    at_cyc(b3 + 29);
    rst_n = 1'b1;

    // period after reset is back to the minimum
    b4 = b3 + 32;
    push_tick(b4 + 1, 1, 1, 0, 0);
    push_tick(b4 + 3, 1, 0, 1, 0);
    push_tick(b4 + 5, 1, 1, 0, 0);
    at_cyc(b4);
    bus.i_enable = 1'b1;
    at_cyc(b4 + 5);
    bus.i_enable = 1'b0;

    at_cyc(b4 + 10);
    done = 1'b1;
  end

endmodule
